hilo_muldiv_ctrl: RTL and testbench

//  Sequencer for all HI/LO writes in the integer pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/muldiv_iter_dp.sv | 62 ++++++
 rtl/hilo_muldiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared HI/LO sequencer definitions: op codes, FSM states, iteration count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

   localparam logic [2:0] HILO_OP_MULT  = 3'd0;
   localparam logic [2:0] HILO_OP_MULTU = 3'd1;
   localparam logic [2:0] HILO_OP_DIV   = 3'd2;
   localparam logic [2:0] HILO_OP_DIVU  = 3'd3;
   localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
   localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

   localparam int MULDIV_ITERS = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_MTX
   } muldiv_state_t;

   // Codes 6 and 7 are not HI/LO writers and must never be accepted.
   function automatic logic hilo_op_legal(input logic [2:0] code);
      return code <= HILO_OP_MTLO;
   endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one shift-add multiply or restoring-divide bit per step.
// Latency: step result is combinational on nxt_hi/nxt_lo, registered on step.
// Backpressure: none; the controlling FSM decides when to load and step.
module muldiv_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] ld_lo,
   input  logic [WIDTH-1:0] ld_opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   // acc_hi:acc_lo is the product (multiply) or remainder:quotient (divide).
   // acc_lo starts as the multiplier / dividend and is consumed one bit per step.
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;

   // Next accumulator value for the current step in either mode.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      nxt_hi    = mul_sum[WIDTH:1];
      nxt_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (div_mode) begin
         // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
         if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Load operands at accept, then advance one bit per iteration cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= ld_lo;
         opnd   <= ld_opnd;
      end else if (step) begin
         acc_hi <= nxt_hi;
         acc_lo <= nxt_lo;
      end
   end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MULT/MULTU/DIV/DIVU iterative, MTHI/MTLO direct.
// Latency: MTxx write 1 cycle after accept; mul/div write 33 cycles after accept.
// Backpressure: op_ready only in IDLE, no queueing; flush aborts any op without a write.
module hilo_muldiv_ctrl
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             op_ready,
   output logic             busy,
   output logic             w_hi,
   output logic [WIDTH-1:0] hi_data,
   output logic             w_lo,
   output logic [WIDTH-1:0] lo_data
);

   localparam int CNT_W = $clog2(MULDIV_ITERS) + 1;

   muldiv_state_t    state;
   logic [CNT_W-1:0] cnt;
   logic             is_div;
   // neg_lo: negate product (mul) or quotient (div); neg_hi: negate remainder.
   logic             neg_lo;
   logic             neg_hi;

   logic             accept;
   logic             signed_op;
   logic             mul_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;
   logic [2*WIDTH-1:0] prod_neg;

   assign op_ready = (state == ST_IDLE);
   assign accept   = op_valid && op_ready && !flush && hilo_op_legal(op_code);

   // Operand magnitudes; unsigned ops pass raw values straight through.
   always_comb begin
      signed_op = (op_code == HILO_OP_MULT) || (op_code == HILO_OP_DIV);
      mul_op    = (op_code == HILO_OP_MULT) || (op_code == HILO_OP_MULTU);
      a_neg     = signed_op && src_a[WIDTH-1];
      b_neg     = signed_op && src_b[WIDTH-1];
      a_mag     = a_neg ? -src_a : src_a;
      b_mag     = b_neg ? -src_b : src_b;
   end

   muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clock    (clock),
      .resetn   (resetn),
      .load     (accept && (op_code <= HILO_OP_DIVU)),
      .step     ((state == ST_MUL) || (state == ST_DIV)),
      .div_mode (state == ST_DIV),
      .ld_lo    (mul_op ? b_mag : a_mag),
      .ld_opnd  (mul_op ? a_mag : b_mag),
      .nxt_hi   (res_hi),
      .nxt_lo   (res_lo)
   );

   // Sign correction applied to the final step result as it is registered out.
   always_comb begin
      prod_neg = -{res_hi, res_lo};
      fix_hi   = res_hi;
      fix_lo   = res_lo;
      if (!is_div) begin
         if (neg_lo) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
         end
      end else begin
         if (neg_lo) fix_lo = -res_lo;
         if (neg_hi) fix_hi = -res_hi;
      end
   end

   // Sequencer FSM with registered busy and HI/LO write outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_lo  <= 1'b0;
         neg_hi  <= 1'b0;
         busy    <= 1'b0;
         w_hi    <= 1'b0;
         w_lo    <= 1'b0;
         hi_data <= '0;
         lo_data <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         w_hi  <= 1'b0;
         w_lo  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               w_hi <= 1'b0;
               w_lo <= 1'b0;
               if (accept) begin
                  if (op_code == HILO_OP_MTHI) begin
                     state   <= ST_MTX;
                     w_hi    <= 1'b1;
                     hi_data <= src_a;
                  end else if (op_code == HILO_OP_MTLO) begin
                     state   <= ST_MTX;
                     w_lo    <= 1'b1;
                     lo_data <= src_a;
                  end else begin
                     state  <= mul_op ? ST_MUL : ST_DIV;
                     busy   <= 1'b1;
                     cnt    <= '0;
                     is_div <= !mul_op;
                     // Divide by zero keeps the all-ones quotient; the remainder
                     // negation still restores the raw dividend for signed DIV.
                     neg_lo <= (a_neg ^ b_neg) && (mul_op || (src_b != '0));
                     neg_hi <= a_neg;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(MULDIV_ITERS - 1)) begin
                  state   <= ST_FIX;
                  w_hi    <= 1'b1;
                  w_lo    <= 1'b1;
                  hi_data <= fix_hi;
                  lo_data <= fix_lo;
               end
            end
            ST_FIX: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               w_hi  <= 1'b0;
               w_lo  <= 1'b0;
            end
            ST_MTX: begin
               state <= ST_IDLE;
               w_hi  <= 1'b0;
               w_lo  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases plus random ops.
// Latency: n/a.
// Backpressure: upstream holds op_valid until op_ready, as EX does.
module tb_hilo_muldiv_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        op_ready;
   logic        busy;
   logic        w_hi;
   logic [31:0] hi_data;
   logic        w_lo;
   logic [31:0] lo_data;

   int n_checks = 0;
   int n_fail   = 0;

   hilo_muldiv_ctrl #(.WIDTH(32)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .op_valid (op_valid),
      .op_code  (op_code),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .op_ready (op_ready),
      .busy     (busy),
      .w_hi     (w_hi),
      .hi_data  (hi_data),
      .w_lo     (w_lo),
      .lo_data  (lo_data)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural HI/LO result computed straight from the instruction semantics.
   task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el);
      logic [63:0] p;
      int q;
      int r;
      eh = '0;
      el = '0;
      case (op)
         3'd0: begin
            p  = 64'(longint'($signed(a)) * longint'($signed(b)));
            eh = p[63:32];
            el = p[31:0];
         end
         3'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
         end
         3'd2: begin
            if (b == 32'd0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               eh = 32'd0;
               el = 32'h8000_0000;
            end else begin
               q  = $signed(a) / $signed(b);
               r  = $signed(a) % $signed(b);
               eh = r;
               el = q;
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               eh = a;
               el = 32'hFFFF_FFFF;
            end else begin
               eh = a % b;
               el = a / b;
            end
         end
         default: ;
      endcase
   endtask

   // Present an op and return #1 after the accepting edge (cycle N+1).
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit seen;
      op_valid = 1'b1;
      op_code  = op;
      src_a    = a;
      src_b    = b;
      seen     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (op_ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clock);
      #1;
      op_valid = 1'b0;
   endtask

   // Watch cycles N+1..N+34 of a mul/div op started by start_op.
   task automatic check_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh;
      logic [31:0] el;
      int early;
      int nbusy;
      ref_model(op, a, b, eh, el);
      early = 0;
      nbusy = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         if (busy) nbusy++;
         if (k < 33 && (w_hi || w_lo)) early++;
      end
      chk("md_w_hi", 64'(w_hi), 64'd1);
      chk("md_w_lo", 64'(w_lo), 64'd1);
      chk("md_hi", 64'(hi_data), 64'(eh));
      chk("md_lo", 64'(lo_data), 64'(el));
      chk("md_early_write", 64'(early), 64'd0);
      chk("md_busy_cycles", 64'(nbusy), 64'd33);
      @(negedge clock);
      chk("md_done_busy", 64'(busy), 64'd0);
      chk("md_done_ready", 64'(op_ready), 64'd1);
      chk("md_done_w", 64'({w_hi, w_lo}), 64'd0);
   endtask

   task automatic check_mtx(input logic [2:0] op, input logic [31:0] a);
      @(negedge clock);
      chk("mtx_w_hi", 64'(w_hi), 64'(op == 3'd4));
      chk("mtx_w_lo", 64'(w_lo), 64'(op == 3'd5));
      chk("mtx_data", 64'((op == 3'd4) ? hi_data : lo_data), 64'(a));
      chk("mtx_busy", 64'(busy), 64'd0);
      @(negedge clock);
      chk("mtx_w_after", 64'({w_hi, w_lo}), 64'd0);
      chk("mtx_busy_after", 64'(busy), 64'd0);
      chk("mtx_ready_after", 64'(op_ready), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_w"}, 64'({w_hi, w_lo}), 64'd0);
      chk({tag, "_hi"}, 64'(hi_data), 64'd0);
      chk({tag, "_lo"}, 64'(lo_data), 64'd0);
      chk({tag, "_ready"}, 64'(op_ready), 64'd1);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          nw;

      resetn   = 1'b0;
      op_valid = 1'b0;
      op_code  = 3'd0;
      src_a    = '0;
      src_b    = '0;
      flush    = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // Directed cases
      start_op(3'd0, 32'hFFFF_FFFF, 32'd2);
      check_muldiv(3'd0, 32'hFFFF_FFFF, 32'd2);
      start_op(3'd1, 32'hFFFF_FFFF, 32'd2);
      check_muldiv(3'd1, 32'hFFFF_FFFF, 32'd2);
      start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
      check_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2);
      start_op(3'd3, 32'd7, 32'd0);
      check_muldiv(3'd3, 32'd7, 32'd0);
      start_op(3'd2, 32'hFFFF_FFF9, 32'd0);
      check_muldiv(3'd2, 32'hFFFF_FFF9, 32'd0);
      start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      check_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      start_op(3'd4, 32'h1234_5678, 32'd0);
      check_mtx(3'd4, 32'h1234_5678);
      start_op(3'd5, 32'hCAFE_F00D, 32'd0);
      check_mtx(3'd5, 32'hCAFE_F00D);

      // Flush a DIVU at N+10: idle at N+11, no write afterwards
      start_op(3'd3, 32'd1000, 32'd7);
      repeat (9) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_ready", 64'(op_ready), 64'd1);
      nw = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (w_hi || w_lo) nw++;
      end
      chk("flush_no_write", 64'(nw), 64'd0);

      // Flush on the last iteration cancels the pending FIX write
      start_op(3'd0, 32'd9, 32'd9);
      repeat (31) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      chk("flush_fix_w", 64'({w_hi, w_lo}), 64'd0);
      chk("flush_fix_busy", 64'(busy), 64'd0);

      // Flush with op_valid in IDLE: not accepted
      @(negedge clock);
      op_valid = 1'b1;
      op_code  = 3'd4;
      src_a    = 32'hDEAD_BEEF;
      flush    = 1'b1;
      @(posedge clock);
      #1;
      op_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_idle_w", 64'({w_hi, w_lo}), 64'd0);
      chk("flush_idle_ready", 64'(op_ready), 64'd1);

      // Illegal op codes are ignored
      op_valid = 1'b1;
      op_code  = 3'd6;
      repeat (2) @(posedge clock);
      op_code = 3'd7;
      repeat (2) @(posedge clock);
      #1 op_valid = 1'b0;
      chk("illegal_ready", 64'(op_ready), 64'd1);
      chk("illegal_busy", 64'(busy), 64'd0);
      chk("illegal_w", 64'({w_hi, w_lo}), 64'd0);

      // Reset in the middle of a MULT, then a clean MULTU
      start_op(3'd0, 32'h0001_2345, 32'h0000_0F0F);
      repeat (19) @(posedge clock);
      #1 resetn = 1'b0;
      #1 check_reset_outputs("midreset");
      @(posedge clock);
      #1 resetn = 1'b1;
      start_op(3'd1, 32'd3, 32'd5);
      check_muldiv(3'd1, 32'd3, 32'd5);

      // Back-to-back: second request held through busy, accepted at first IDLE
      start_op(3'd2, 32'd100, 32'hFFFF_FFFD);
      op_valid = 1'b1;
      op_code  = 3'd0;
      src_a    = 32'hFFFF_8000;
      src_b    = 32'h0001_0003;
      check_muldiv(3'd2, 32'd100, 32'hFFFF_FFFD);
      @(posedge clock);
      #1 op_valid = 1'b0;
      check_muldiv(3'd0, 32'hFFFF_8000, 32'h0001_0003);

      // Random ops against the reference model
      for (int t = 0; t < 24; t++) begin
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         start_op(op, a, b);
         if (op >= 3'd4) check_mtx(op, a);
         else check_muldiv(op, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
